// File: rtl/mem_pkg.sv
// Shared types and constants for the unified instruction/data memory port.
// Used by unified_memory_port and sp_ram.
package mem_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam logic [31:0] BASE_ADDR_DEF = 32'h0000_0BB8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INST_RSP = 2'd1,
        DATA_RSP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ACC_NONE    = 3'd0,
        ACC_PROG    = 3'd1,
        ACC_DATA_RD = 3'd2,
        ACC_DATA_WR = 3'd3,
        ACC_INST    = 3'd4
    } acc_t;

    // Word-window membership of a byte offset already rebased to word 0.
    function automatic logic inWindow(input logic [31:0] offset, input logic [31:0] span);
        return (offset < span);
    endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM with a registered read port (read-first).
// Contents have no reset.
module sp_ram
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  index,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_r [DEPTH];

    // Storage write and registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[index] <= wdata;
        end
        rdata <= mem_r[index];
    end

endmodule

// File: rtl/unified_memory_port.sv
// Unified I/D memory port: arbitrates program, data and fetch ports onto one RAM
// with one-cycle registered responses. Optional MEM_ALIGN_CHECK_EN faults misaligned inst/data accesses.
module unified_memory_port
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_wdata,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] inst_rdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_ready,
    output logic        data_valid,
    output logic [31:0] data_rdata,
    output logic        access_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [31:0] SPAN  = 32'(DEPTH) * 32'd4;

    logic              dataReq_s;
    acc_t              acc_s;
    logic [31:0]       selAddr_s;
    logic [31:0]       offset_s;
    logic              inRange_s;
    logic              alignFault_s;
    logic              ramWe_s;
    logic [IDX_W-1:0]  ramIdx_s;
    logic [31:0]       ramWdata_s;
    logic [31:0]       ramRdata_s;
    logic              rspPass_s;
    logic              rspErr_s;
    state_t            state_r;
    state_t            stateNext_s;
    logic              rspPass_r;
    logic              rspErr_r;

    assign dataReq_s  = mem_read | mem_write;
    assign data_ready = dataReq_s & ~prog_we & ~reset;
    assign inst_ready = inst_req & ~prog_we & ~dataReq_s & ~reset;

    // Fixed-priority arbitration: program > data > fetch.
    always_comb begin
        acc_s      = ACC_NONE;
        selAddr_s  = 32'h0000_0000;
        ramWdata_s = 32'h0000_0000;
        if (reset) begin
            acc_s = ACC_NONE;
        end else if (prog_we) begin
            acc_s      = ACC_PROG;
            selAddr_s  = prog_addr;
            ramWdata_s = prog_wdata;
        end else if (dataReq_s) begin
            acc_s      = mem_write ? ACC_DATA_WR : ACC_DATA_RD;
            selAddr_s  = data_addr;
            ramWdata_s = data_wdata;
        end else if (inst_req) begin
            acc_s     = ACC_INST;
            selAddr_s = inst_addr;
        end else begin
            acc_s = ACC_NONE;
        end
    end

    assign offset_s  = selAddr_s - BASE_ADDR;
    assign inRange_s = inWindow(offset_s, SPAN);
    assign ramIdx_s  = offset_s[IDX_W+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    assign alignFault_s = (acc_s != ACC_PROG) && (selAddr_s[1:0] != 2'b00);
`else
    assign alignFault_s = 1'b0;
`endif

    // Access qualification: faulting writes are dropped, faulting reads return zero.
    always_comb begin
        ramWe_s   = 1'b0;
        rspPass_s = 1'b0;
        rspErr_s  = 1'b0;
        case (acc_s)
            ACC_PROG: begin
                ramWe_s = inRange_s;
            end
            ACC_DATA_WR: begin
                ramWe_s  = inRange_s & ~alignFault_s;
                rspErr_s = ~inRange_s | alignFault_s | mem_read;
            end
            ACC_DATA_RD, ACC_INST: begin
                rspPass_s = inRange_s & ~alignFault_s;
                rspErr_s  = ~inRange_s | alignFault_s;
            end
            default: begin
                ramWe_s = 1'b0;
            end
        endcase
    end

    sp_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ramWe_s),
        .index (ramIdx_s),
        .wdata (ramWdata_s),
        .rdata (ramRdata_s)
    );

    // Response state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Next state depends only on what was accepted this cycle, whatever the current state.
    always_comb begin
        stateNext_s = IDLE;
        if (data_ready) begin
            stateNext_s = DATA_RSP;
        end else if (inst_ready) begin
            stateNext_s = INST_RSP;
        end else begin
            stateNext_s = IDLE;
        end
    end

    // Response qualifiers captured alongside the RAM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rspPass_r <= 1'b0;
            rspErr_r  <= 1'b0;
        end else begin
            rspPass_r <= rspPass_s;
            rspErr_r  <= rspErr_s;
        end
    end

    // Response outputs; a reset arriving mid-access discards the pending response.
    always_comb begin
        inst_valid = 1'b0;
        inst_rdata = 32'h0000_0000;
        data_valid = 1'b0;
        data_rdata = 32'h0000_0000;
        access_err = 1'b0;
        case (state_r)
            IDLE: begin
                access_err = 1'b0;
            end
            INST_RSP: begin
                inst_valid = ~reset;
                inst_rdata = (rspPass_r & ~reset) ? ramRdata_s : 32'h0000_0000;
                access_err = rspErr_r & ~reset;
            end
            DATA_RSP: begin
                data_valid = ~reset;
                data_rdata = (rspPass_r & ~reset) ? ramRdata_s : 32'h0000_0000;
                access_err = rspErr_r & ~reset;
            end
            default: begin
                access_err = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_unified_memory_port.sv
// Scoreboard bench for unified_memory_port: directed requests push expected responses,
// a negedge monitor pops and compares each presented response.
module tb_unified_memory_port;

    typedef struct packed {
        logic        isData;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_wdata;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ready;
    logic        data_valid;
    logic [31:0] data_rdata;
    logic        access_err;

    exp_t expQ[$];
    int   vecCount  = 0;
    int   failCount = 0;

    unified_memory_port dut (
        .clk        (clk),
        .reset      (reset),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_ready (inst_ready),
        .inst_valid (inst_valid),
        .inst_rdata (inst_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_ready (data_ready),
        .data_valid (data_valid),
        .data_rdata (data_rdata),
        .access_err (access_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clrInputs();
        prog_we    = 1'b0;
        prog_addr  = 32'h0;
        prog_wdata = 32'h0;
        inst_req   = 1'b0;
        inst_addr  = 32'h0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
        clrInputs();
    endtask

    task automatic progWr(input logic [31:0] addr, input logic [31:0] data);
        nextCycle();
        prog_we    = 1'b1;
        prog_addr  = addr;
        prog_wdata = data;
    endtask

    task automatic instRd(input logic [31:0] addr, input logic [31:0] expData, input logic expErr);
        nextCycle();
        inst_req  = 1'b1;
        inst_addr = addr;
        #1;
        chk("inst_ready", 32'(inst_ready), 32'd1);
        expQ.push_back('{isData: 1'b0, rdata: expData, err: expErr});
    endtask

    task automatic dataRd(input logic [31:0] addr, input logic [31:0] expData, input logic expErr);
        nextCycle();
        mem_read  = 1'b1;
        data_addr = addr;
        #1;
        chk("data_ready_rd", 32'(data_ready), 32'd1);
        expQ.push_back('{isData: 1'b1, rdata: expData, err: expErr});
    endtask

    task automatic dataWr(input logic [31:0] addr, input logic [31:0] wdata, input logic expErr);
        nextCycle();
        mem_write  = 1'b1;
        data_addr  = addr;
        data_wdata = wdata;
        #1;
        chk("data_ready_wr", 32'(data_ready), 32'd1);
        expQ.push_back('{isData: 1'b1, rdata: 32'h0, err: expErr});
    endtask

    // Response monitor: every presented valid must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (inst_valid || data_valid) begin
            chk("dual_valid", 32'(inst_valid & data_valid), 32'd0);
            if (expQ.size() == 0) begin
                vecCount++;
                failCount++;
                $display("FAIL unexpected_valid: inst_valid=%b data_valid=%b with empty scoreboard at %0t",
                         inst_valid, data_valid, $time);
            end else begin
                e = expQ.pop_front();
                chk("rsp_port", 32'(data_valid), 32'(e.isData));
                chk("rsp_rdata", data_valid ? data_rdata : inst_rdata, e.rdata);
                chk("rsp_err", 32'(access_err), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clrInputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_access_err", 32'(access_err), 32'd0);
        chk("rst_inst_rdata", inst_rdata, 32'h0);
        chk("rst_data_rdata", data_rdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Preload, including an out-of-range and a byte-offset program write.
        progWr(32'h0000_0BB8, 32'h8C08_0010);
        progWr(32'h0000_0BBC, 32'h1111_1111);
        progWr(32'h0000_0BC8, 32'h2222_2222);
        progWr(32'h0000_1000, 32'h3333_3333);
        progWr(32'h0000_1BB4, 32'h4444_4444);
        progWr(32'h0000_1BB8, 32'h7777_7777);
        progWr(32'h0000_0C0A, 32'h6666_6666);

        // Program port blocks a simultaneous fetch.
        nextCycle();
        prog_we    = 1'b1;
        prog_addr  = 32'h0000_0C10;
        prog_wdata = 32'h1234_5678;
        inst_req   = 1'b1;
        inst_addr  = 32'h0000_0BB8;
        #1;
        chk("inst_ready_vs_prog", 32'(inst_ready), 32'd0);
        instRd(32'h0000_0BB8, 32'h8C08_0010, 1'b0);

        // Data beats fetch in the same cycle.
        nextCycle();
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0BBC;
        mem_read  = 1'b1;
        data_addr = 32'h0000_0BC8;
        #1;
        chk("collide_data_ready", 32'(data_ready), 32'd1);
        chk("collide_inst_ready", 32'(inst_ready), 32'd0);
        expQ.push_back('{isData: 1'b1, rdata: 32'h2222_2222, err: 1'b0});
        instRd(32'h0000_0BBC, 32'h1111_1111, 1'b0);

        // Store then load on consecutive cycles.
        dataWr(32'h0000_0C00, 32'hDEAD_BEEF, 1'b0);
        dataRd(32'h0000_0C00, 32'hDEAD_BEEF, 1'b0);

        // Range boundaries; the dropped write at 0 would alias to word 0x1000.
        dataRd(32'h0000_0000, 32'h0, 1'b1);
        dataWr(32'h0000_0000, 32'hCAFE_F00D, 1'b1);
        dataRd(32'h0000_1000, 32'h3333_3333, 1'b0);
        dataRd(32'h0000_0BB8, 32'h8C08_0010, 1'b0);
        dataRd(32'h0000_1BB4, 32'h4444_4444, 1'b0);
        dataRd(32'h0000_1BB8, 32'h0, 1'b1);
        instRd(32'h0000_0BB4, 32'h0, 1'b1);

        // Read and write together: faulting store that still commits.
        nextCycle();
        mem_read   = 1'b1;
        mem_write  = 1'b1;
        data_addr  = 32'h0000_0C04;
        data_wdata = 32'h5555_5555;
        #1;
        chk("rw_data_ready", 32'(data_ready), 32'd1);
        expQ.push_back('{isData: 1'b1, rdata: 32'h0, err: 1'b1});
        dataRd(32'h0000_0C04, 32'h5555_5555, 1'b0);
        dataRd(32'h0000_0C08, 32'h6666_6666, 1'b0);
        dataRd(32'h0000_0C10, 32'h1234_5678, 1'b0);

        // Misaligned inst/data accesses.
`ifdef MEM_ALIGN_CHECK_EN
        instRd(32'h0000_0BB9, 32'h0, 1'b1);
        dataRd(32'h0000_0C02, 32'h0, 1'b1);
        dataWr(32'h0000_0C06, 32'h9999_9999, 1'b1);
        dataRd(32'h0000_0C04, 32'h5555_5555, 1'b0);
`else
        instRd(32'h0000_0BB9, 32'h8C08_0010, 1'b0);
        dataRd(32'h0000_0C02, 32'hDEAD_BEEF, 1'b0);
        dataWr(32'h0000_0C06, 32'h9999_9999, 1'b0);
        dataRd(32'h0000_0C04, 32'h9999_9999, 1'b0);
`endif

        // Back-to-back fetches.
        instRd(32'h0000_0BB8, 32'h8C08_0010, 1'b0);
        instRd(32'h0000_0BBC, 32'h1111_1111, 1'b0);

        // Reset mid-access: accepted read is discarded, RAM survives.
        nextCycle();
        mem_read  = 1'b1;
        data_addr = 32'h0000_0C00;
        #1;
        chk("pre_reset_data_ready", 32'(data_ready), 32'd1);
        nextCycle();
        reset     = 1'b1;
        mem_read  = 1'b1;
        data_addr = 32'h0000_0C00;
        #1;
        chk("reset_data_ready", 32'(data_ready), 32'd0);
        @(negedge clk);
        chk("reset_cycle_data_valid", 32'(data_valid), 32'd0);
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_data_valid", 32'(data_valid), 32'd0);
        dataRd(32'h0000_0C00, 32'hDEAD_BEEF, 1'b0);
        instRd(32'h0000_0BB8, 32'h8C08_0010, 1'b0);

        nextCycle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
